uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive side of the FISC UART, complementing the existing transmit-only UART. Deserialises 8N1 frames from the `rxd` pin into a small FIFO. Presents the FIFO head as the UART data-bus source selected by the active-low UART data-bus write strobe. Exports a receive-available status line and error flags to the jump logic's UART status inputs.

## Interface
- `ClkDiv`, default 16: `i_clk` cycles per serial bit; even, ≥4.
- `FifoDepth`, default 4: receive FIFO entries; power of two, ≥2.
- `i_clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial input; idle high; asynchronous to `i_clk`.
- `rd_n`  in  1  active-low read strobe, driven by the data-bus writer demux UART output.
- `data`  out  8  FIFO head byte; 0x00 when the FIFO is empty.
- `rx_avail`  out  1  active high, FIFO non-empty; drives a jump-logic status input.
- `overrun`  out  1  sticky; a completed byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled low.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- Bit counter counts `ClkDiv` cycles per bit; half-bit point is `ClkDiv/2`.
- FSM states:
  - IDLE: on a synchronised falling edge → START.
  - START: at the half-bit point, sample. A 0 → DATA with bit index 0. A 1 is a false start → IDLE with no flag.
  - DATA: sample every `ClkDiv` cycles, LSB first. After bit 7 → STOP.
  - STOP: sample after `ClkDiv` cycles.
    - Stop bit 1: push the byte.
    - Stop bit 0: discard the byte, set `frame_err`, wait in STOP until `rxd` is high, then → IDLE.
- Push with the FIFO full: byte dropped, `overrun` set, FIFO contents unchanged.
- Pop happens on the rising edge of `rd_n`: the registered `rd_n` was 0 and the current `rd_n` is 1. Exactly one pop per low pulse, however long the pulse.
- `data` stays stable for the whole low phase of `rd_n`.
- Pop with the FIFO empty: no effect.
- A pop that removes an entry clears both `overrun` and `frame_err`.
- Simultaneous push and pop: both take effect. When full, the pop is applied first and the push is accepted.
- Reset values:
  - FSM in IDLE; counters 0.
  - FIFO empty; `data`=0x00; `rx_avail`=0.
  - `overrun`=0; `frame_err`=0.
- Reset asserted mid-frame or mid-read abandons everything and returns to the reset values immediately. The receiver then needs a fresh falling edge to start a frame.

## Timing
- Start-bit detection lags the `rxd` edge by 2 cycles (synchroniser).
- Stop sample occurs `ClkDiv/2 + 9*ClkDiv` cycles after detection.
- Push occurs on the following edge. `rx_avail`, `data` and the flags update on that push edge.
- End-to-end: `rx_avail` rises `ClkDiv/2 + 9*ClkDiv + 3` cycles after the `rxd` falling edge (155 for `ClkDiv`=16), ±1 cycle for synchroniser phase.
- After a pop, `data` and `rx_avail` update on the same edge that detects the `rd_n` rise.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1: an even-parity bit follows bit 7 and is sampled `ClkDiv` later.
  - Stop sample moves out by `ClkDiv`.
  - Adds output `parity_err` (sticky, reset 0, cleared by a pop like the other flags).
  - A byte with bad parity is still pushed.
- `UART_RX_PARITY_EN` undefined: 8N1 only; no `parity_err` port.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Default `ClkDiv` and `FifoDepth` constants.
  - Frame bit-count constant, which depends on `UART_RX_PARITY_EN`.
- Sub-module `uart_rx_fifo`:
  - Synchronous push/pop, `FifoDepth` entries.
  - Pointers one bit wider than the index, for the full/empty test.
  - Async reset to empty; head word output combinationally.
- Top level holds the synchroniser, bit counter, FSM, shift register, `rd_n` edge detect and sticky flags.

## Test plan
- Send 0x55 at `ClkDiv`=16 → `rx_avail`=1 about 155 cycles after the start edge, `data`=0x55; pulse `rd_n` low for 3 cycles → `data` stays 0x55 while low, then `rx_avail`=0 and `data`=0x00 after the rise.
- 0.25-bit low glitch on idle `rxd` → no push, no flags, FSM back in IDLE.
- Send 0xA3 with stop bit forced 0 → `frame_err`=1, `rx_avail`=0; then send 0x3C → pushed; pop → `data` was 0x3C, `frame_err` cleared.
- Send 5 bytes 0x01..0x05 with no reads (`FifoDepth`=4) → `overrun`=1; pops return 0x01..0x04, then `rx_avail`=0.
- FIFO full; pop `rd_n` rise on the same edge as the push of 0x77 → no overrun; 0x77 becomes the 4th entry.
- Assert `reset` during data bit 4 of 0x99 → all outputs at reset values the same cycle; the next full frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FISC receive UART.
// UART_RX_PARITY_EN selects an 8E1 frame instead of 8N1 and changes FRAME_BITS.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int CLK_DIV_DEFAULT    = 16;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int DATA_BITS          = 8;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
`else
    localparam int FRAME_BITS = 10;   // start + 8 data + stop
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: synchronous push/pop, extra pointer bit for full/empty, head shown combinationally.
module uart_rx_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // When full, a concurrent pop frees the head slot, so the push may land in it.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// FISC UART receiver: 8N1 deserialiser into a small FIFO, popped on the rising edge of rd_n.
// Define UART_RX_PARITY_EN for 8E1 frames and the extra parity_err flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClkDiv    = CLK_DIV_DEFAULT,
    parameter int FifoDepth = FIFO_DEPTH_DEFAULT
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_n,
    output logic [7:0] data,
    output logic       rx_avail,
    output logic       overrun,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CNT_W = $clog2(ClkDiv);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(ClkDiv / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(ClkDiv - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);

    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 sync3_reg;
    logic                 rx_bit;
    logic                 fall;

    rx_state_t            state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [7:0]           shift_reg;
    logic                 stop_bad_reg;
    logic                 push_reg;
    logic                 ferr_set_reg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_reg;
    logic                 perr_set_reg;
`endif

    logic                 rd_n_reg;
    logic                 pop_edge;
    logic                 pop;
    logic [7:0]           head;
    logic                 empty;
    logic                 full;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            sync3_reg <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign rx_bit = sync2_reg;
    assign fall   = sync3_reg & ~sync2_reg;

    // Counter starts at 1 in START so the start sample lands ClkDiv/2 after the synchronised edge.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            stop_bad_reg <= 1'b0;
            push_reg     <= 1'b0;
            ferr_set_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg  <= 1'b0;
            perr_set_reg <= 1'b0;
`endif
        end else begin
            push_reg     <= 1'b0;
            ferr_set_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_set_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        state_reg <= START;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_bit ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_bit, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg     <= '0;
                        par_bit_reg <= rx_bit;
                        state_reg   <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (stop_bad_reg) begin
                        // Line must return high before another start edge can be trusted.
                        if (rx_bit) begin
                            stop_bad_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end else if (cnt_reg == FULL_LAST) begin
                        cnt_reg <= '0;
                        if (rx_bit) begin
                            push_reg  <= 1'b1;
                            state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
                            perr_set_reg <= ^{shift_reg, par_bit_reg};
`endif
                        end else begin
                            ferr_set_reg <= 1'b1;
                            stop_bad_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rd_n_reg <= 1'b1;
        end else begin
            rd_n_reg <= rd_n;
        end
    end

    assign pop_edge = ~rd_n_reg & rd_n;
    assign pop      = pop_edge & ~empty;

    uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (reset),
        .push  (push_reg),
        .pop   (pop_edge),
        .din   (shift_reg),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    // New error events win over a pop-clear in the same cycle.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (pop) begin
                overrun    <= 1'b0;
                frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (push_reg && full && !pop_edge) begin
                overrun <= 1'b1;
            end
            if (ferr_set_reg) begin
                frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (perr_set_reg) begin
                parity_err <= 1'b1;
            end
`endif
        end
    end

    assign rx_avail = ~empty;
    assign data     = empty ? 8'h00 : head;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit on rxd, FIFO popped via rd_n pulses.
// Honours UART_RX_PARITY_EN for the port list and the driven frame shape.
module tb_uart_rx;

    localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = CLK_DIV / 2 + 10 * CLK_DIV + 3;
`else
    localparam int LAT = CLK_DIV / 2 + 9 * CLK_DIV + 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rd_n;
    logic [7:0] data;
    logic       rx_avail;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(
        .ClkDiv    (CLK_DIV),
        .FifoDepth (4)
    ) dut (
        .i_clk     (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_n      (rd_n),
        .data      (data),
        .rx_avail  (rx_avail),
        .overrun   (overrun),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    // Three-cycle low pulse; the head must hold for the whole low phase.
    task automatic pop_byte(input string tag, input logic [7:0] exp);
        rd_n = 1'b0;
        check({tag, "_head"}, int'(data), int'(exp));
        repeat (3) begin
            @(negedge clk);
            check({tag, "_hold"}, int'(data), int'(exp));
        end
        rd_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int         n;
        logic [7:0] b;

        reset = 1'b1;
        rxd   = 1'b1;
        rd_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", int'(data), 0);
        check("rst_avail", int'(rx_avail), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x55 with latency measurement from the rxd falling edge
        n = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (!rx_avail && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check("avail_latency", (n >= LAT - 1 && n <= LAT + 1) ? LAT : n, LAT);
        check("rx55_data", int'(data), 8'h55);
        pop_byte("pop55", 8'h55);
        check("pop55_avail", int'(rx_avail), 0);
        check("pop55_data", int'(data), 0);

        // quarter-bit glitch is rejected as a false start
        rxd = 1'b0;
        repeat (CLK_DIV / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_avail", int'(rx_avail), 0);
        check("glitch_frame_err", int'(frame_err), 0);
        check("glitch_overrun", int'(overrun), 0);

        // bad stop bit, then a good frame, then pop clears the flag
        send_byte(8'hA3, 1'b0);
        repeat (8) @(negedge clk);
        check("ferr_set", int'(frame_err), 1);
        check("ferr_avail", int'(rx_avail), 0);
        send_byte(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check("rx3c_avail", int'(rx_avail), 1);
        check("ferr_sticky", int'(frame_err), 1);
        pop_byte("pop3c", 8'h3C);
        check("ferr_cleared", int'(frame_err), 0);
        check("pop3c_avail", int'(rx_avail), 0);

        // five back-to-back bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (8) @(negedge clk);
        check("ovr_set", int'(overrun), 1);
        check("ovr_head", int'(data), 8'h01);
        pop_byte("ovr_pop1", 8'h01);
        check("ovr_cleared", int'(overrun), 0);
        pop_byte("ovr_pop2", 8'h02);
        pop_byte("ovr_pop3", 8'h03);
        pop_byte("ovr_pop4", 8'h04);
        check("ovr_drained_avail", int'(rx_avail), 0);
        check("ovr_drained_data", int'(data), 0);

        // full FIFO: rd_n rise lands on the same edge as the push of 0x77
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b1);
        repeat (8) @(negedge clk);
        check("full_no_ovr", int'(overrun), 0);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (LAT - 5) @(negedge clk);
                rd_n = 1'b0;
                repeat (4) @(negedge clk);
                rd_n = 1'b1;
            end
        join
        check("simul_overrun", int'(overrun), 0);
        check("simul_head", int'(data), 8'h11);
        pop_byte("simul_pop1", 8'h11);
        pop_byte("simul_pop2", 8'h12);
        pop_byte("simul_pop3", 8'h13);
        pop_byte("simul_pop4", 8'h77);
        check("simul_avail", int'(rx_avail), 0);

        // reset during data bit 4 of 0x99 with state already present
        send_byte(8'hA3, 1'b0);
        repeat (8) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        check("pre_rst_ferr", int'(frame_err), 1);
        check("pre_rst_avail", int'(rx_avail), 1);
        b = 8'h99;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rxd = b[4];
        repeat (CLK_DIV / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_data", int'(data), 0);
        check("midrst_avail", int'(rx_avail), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_overrun", int'(overrun), 0);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (CLK_DIV * 6) @(negedge clk);
        check("postrst_idle", int'(rx_avail), 0);
        send_byte(8'h42, 1'b1);
        repeat (8) @(negedge clk);
        check("postrst_avail", int'(rx_avail), 1);
        pop_byte("postrst_pop", 8'h42);
        check("postrst_empty", int'(rx_avail), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
